// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO with a valid/ready write port.
// Frame: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop.
// tx and tx_busy are registered from the current FSM state, so the line lags the FSM by one clock.
module uart_tx_fifo #(
    parameter int unsigned BAUD_DIV   = 5208,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            s_valid,
    input  logic [DATA_BITS-1:0]            s_data,
    output logic                            s_ready,
    output logic                            tx,
    output logic                            tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    localparam int unsigned CntW = $clog2(BAUD_DIV);
    localparam int unsigned BitW = $clog2(DATA_BITS);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);
    localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      baud_q, baud_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]      level_q, level_d;

    logic                 push;
    logic                 pop;
    logic                 baud_end;
    logic [DATA_BITS-1:0] head;

    assign s_ready    = (level_q != LvlW'(FIFO_DEPTH));
    assign push       = s_valid && s_ready;
    assign head       = mem_q[rd_ptr_q];
    assign baud_end   = (baud_q == BaudLast);
    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign fifo_level = level_q;

    // FIFO next state; pointers wrap naturally since FIFO_DEPTH is a power of two
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = s_data;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LvlW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LvlW'(1);
        end
    end

    // Frame sequencer: next state, bit/baud counters, shift register and parity accumulator
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        baud_d  = (state_q == StIdle || baud_end) ? '0 : baud_q + CntW'(1);
        case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = StStart;
                    shift_d = head;
                    par_d   = 1'b0;
                    bit_d   = '0;
                end
            end
            StStart: begin
                if (baud_end) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    par_d   = par_q ^ shift_q[0];
                    if (bit_q == DataLast) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            StParity: begin
                if (baud_end) begin
                    state_d = StStop;
                    bit_d   = '0;
                end
            end
            StStop: begin
                if (baud_end) begin
                    if (bit_q == StopLast) begin
                        bit_d = '0;
                        // Chain straight into the next start bit when more data is queued
                        if (level_q != '0) begin
                            pop     = 1'b1;
                            state_d = StStart;
                            shift_d = head;
                            par_d   = 1'b0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level and busy flag decoded from the current state, registered below
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_q != StIdle);
        case (state_q)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_q[0];
            StParity: tx_d = (PARITY == 1) ? ~par_q : par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    // State registers; reset aborts any frame and drops queued data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover 8N1, 8E2, 8O2 and 5N1 framing.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       s_valid;
    logic [7:0] s_data;
    int         sel;

    logic       sv_a, sv_e, sv_o, sv_5;
    logic       rdy_a, rdy_e, rdy_o, rdy_5;
    logic       tx_a, tx_e, tx_o, tx_5;
    logic       busy_a, busy_e, busy_o, busy_5;
    logic [2:0] lvl_a, lvl_e, lvl_o, lvl_5;
    logic       tx_m, busy_m;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] bits;
    int           blen, lat;
    int           held, viol, maxlvl, bad;
    logic [7:0]   exp_stream [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    logic [7:0]   exp_pp     [4] = '{8'h3C, 8'hC3, 8'h5A, 8'h81};

    assign sv_a = s_valid && (sel == 0);
    assign sv_e = s_valid && (sel == 1);
    assign sv_o = s_valid && (sel == 2);
    assign sv_5 = s_valid && (sel == 3);

    always_comb begin
        tx_m   = tx_a;
        busy_m = busy_a;
        case (sel)
            1: begin tx_m = tx_e; busy_m = busy_e; end
            2: begin tx_m = tx_o; busy_m = busy_o; end
            3: begin tx_m = tx_5; busy_m = busy_5; end
            default: begin tx_m = tx_a; busy_m = busy_a; end
        endcase
    end

    uart_tx_fifo #(.BAUD_DIV(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rstn(rstn), .s_valid(sv_a), .s_data(s_data), .s_ready(rdy_a),
        .tx(tx_a), .tx_busy(busy_a), .fifo_level(lvl_a)
    );
    uart_tx_fifo #(.BAUD_DIV(8), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_e (
        .clk(clk), .rstn(rstn), .s_valid(sv_e), .s_data(s_data), .s_ready(rdy_e),
        .tx(tx_e), .tx_busy(busy_e), .fifo_level(lvl_e)
    );
    uart_tx_fifo #(.BAUD_DIV(8), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_o (
        .clk(clk), .rstn(rstn), .s_valid(sv_o), .s_data(s_data), .s_ready(rdy_o),
        .tx(tx_o), .tx_busy(busy_o), .fifo_level(lvl_o)
    );
    uart_tx_fifo #(.BAUD_DIV(8), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_5 (
        .clk(clk), .rstn(rstn), .s_valid(sv_5), .s_data(s_data[4:0]), .s_ready(rdy_5),
        .tx(tx_5), .tx_busy(busy_5), .fifo_level(lvl_5)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Waits for the start bit, then samples tx at bit centres until tx_busy drops.
    task automatic capture(input int nbits, output logic [127:0] cbits, output int clen,
                           output int clat);
        cbits = '0;
        clen  = 0;
        clat  = 0;
        while (tx_m !== 1'b0 && clat < 400) begin
            @(posedge clk); #1;
            clat++;
        end
        if (clat >= 400) begin
            check("tx_fall_timeout", clat, -1);
            return;
        end
        while (busy_m === 1'b1 && clen < 2000) begin
            if (clen % 8 == 4 && clen / 8 < nbits) cbits[clen/8] = tx_m;
            clen++;
            @(posedge clk); #1;
        end
    endtask

    // Single push into an idle instance; exp lists line bits in send order.
    task automatic frame_test(input string tag, input int which, input logic [7:0] d,
                              input string exp);
        logic [127:0] fb;
        int fl, ft, got, want;
        sel = which;
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk); #1;
        s_valid = 1'b0;
        capture(exp.len(), fb, fl, ft);
        got  = 0;
        want = 0;
        for (int i = 0; i < exp.len(); i++) begin
            got[i]  = fb[i];
            want[i] = (exp[i] == 8'h31);
        end
        check({tag, "_latency"}, ft, 2);
        check({tag, "_busy_clks"}, fl, exp.len() * 8);
        check({tag, "_bits"}, got, want);
    endtask

    initial begin
        rstn    = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        sel     = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx", {tx_a, tx_e, tx_o, tx_5}, 4'b1111);
        check("rst_busy", {busy_a, busy_e, busy_o, busy_5}, 4'b0000);
        check("rst_ready", {rdy_a, rdy_e, rdy_o, rdy_5}, 4'b1111);
        check("rst_level", {lvl_a, lvl_e, lvl_o, lvl_5}, 0);
        @(negedge clk);
        rstn = 1'b1;

        frame_test("8n1_a5", 0, 8'hA5, "0101001011");
        frame_test("8e2_a5", 1, 8'hA5, "010100101011");
        frame_test("8o2_a5", 2, 8'hA5, "010100101111");
        frame_test("5n1_1f", 3, 8'h1F, "0111111");

        // Stream six bytes with s_valid held; FIFO fills and back-pressures
        sel = 0;
        @(posedge clk); #1;
        fork
            begin
                int k, guard;
                logic r;
                k = 0; guard = 0; held = 0; viol = 0; maxlvl = 0;
                while (k < 6 && guard < 300) begin
                    r = rdy_a;
                    if (!r) held++;
                    if (lvl_a == 3'd4 && r) viol++;
                    if (int'(lvl_a) > maxlvl) maxlvl = int'(lvl_a);
                    s_valid = 1'b1;
                    s_data  = exp_stream[k];
                    @(posedge clk); #1;
                    if (r) k++;
                    guard++;
                end
                s_valid = 1'b0;
            end
            capture(60, bits, blen, lat);
        join
        check("stream_max_level", maxlvl, 4);
        check("stream_ready_at_full", viol, 0);
        check("stream_held_cycles", held, 77);
        check("stream_latency", lat, 3);
        check("stream_busy_clks", blen, 480);
        for (int f = 0; f < 6; f++) begin
            check($sformatf("stream_f%0d_data", f), bits[f*10+1 +: 8], exp_stream[f]);
            check($sformatf("stream_f%0d_framing", f), {bits[f*10+9], bits[f*10]}, 2'b10);
        end

        // Push coincides with a pop while two bytes are queued
        @(posedge clk); #1;
        fork
            begin
                s_valid = 1'b1;
                s_data  = 8'h3C;
                @(posedge clk); #1;
                s_data = 8'hC3;
                @(posedge clk); #1;
                s_data = 8'h5A;
                @(posedge clk); #1;
                s_valid = 1'b0;
                check("pp_level_before", lvl_a, 2);
                repeat (78) @(posedge clk);
                #1;
                check("pp_level_pre_edge", lvl_a, 2);
                s_valid = 1'b1;
                s_data  = 8'h81;
                @(posedge clk); #1;
                s_valid = 1'b0;
                check("pp_level_same_edge", lvl_a, 2);
            end
            capture(40, bits, blen, lat);
        join
        check("pp_busy_clks", blen, 320);
        for (int f = 0; f < 4; f++) begin
            check($sformatf("pp_f%0d_data", f), bits[f*10+1 +: 8], exp_pp[f]);
        end

        // Reset in the middle of a data bit with three bytes queued
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = 8'h11;
        @(posedge clk); #1;
        s_data = 8'h22;
        @(posedge clk); #1;
        s_data = 8'h33;
        @(posedge clk); #1;
        s_data = 8'h44;
        @(posedge clk); #1;
        s_valid = 1'b0;
        check("mid_level", lvl_a, 3);
        repeat (17) @(posedge clk);
        #1;
        check("mid_busy", busy_a, 1);
        rstn = 1'b0;
        #1;
        check("arst_tx", tx_a, 1);
        check("arst_busy", busy_a, 0);
        check("arst_level", lvl_a, 0);
        check("arst_ready", rdy_a, 1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || lvl_a != 3'd0) bad++;
        end
        check("post_rst_idle", bad, 0);
        frame_test("post_rst_5a", 0, 8'h5A, "0010110101");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
